// File: rtl/qsys_irq_pkg.sv
// Shared definitions for the Qsys interrupt aggregator: register map and bus widths.
package qsys_irq_pkg;

  localparam int IRQ_DATA_W       = 16;
  localparam int IRQ_ADDR_W       = 3;
  localparam int VECTOR_VALID_BIT = 15;

  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_PENDING = 3'd0;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_MASK    = 3'd1;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_MODE    = 3'd2;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_ACTIVE  = 3'd3;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_VECTOR  = 3'd4;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_SET     = 3'd5;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_RAW     = 3'd6;

endpackage

// File: rtl/qsys_irq_if.sv
// Avalon-MM slave bus of the interrupt aggregator (single-cycle, no wait states).
interface qsys_irq_if;
  import qsys_irq_pkg::*;

  logic [IRQ_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [IRQ_DATA_W-1:0] writedata;
  logic [IRQ_DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/qsys_irq_prio_enc.sv
// Lowest-index-first priority encoder: line 0 wins; idx is 0 when nothing is requesting.
module qsys_irq_prio_enc #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Descending scan so the last hit, i.e. the lowest index, is what remains.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/qsys_irq_ctrl.sv
// Interrupt aggregator: per-line level/rising-edge capture, mask, priority vector,
// and one registered irq_out to the CPU.
module qsys_irq_ctrl
  import qsys_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  qsys_irq_if.slave          bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0]    sync;
  logic [NUM_IRQ-1:0]    prev_q;
  logic [NUM_IRQ-1:0]    mask_q;
  logic [NUM_IRQ-1:0]    mode_q;
  logic [NUM_IRQ-1:0]    latch_q;
  logic [NUM_IRQ-1:0]    latch_d;
  logic [NUM_IRQ-1:0]    pending;
  logic [NUM_IRQ-1:0]    active;
  logic [NUM_IRQ-1:0]    wdata;
  logic [NUM_IRQ-1:0]    w1c_bits;
  logic [NUM_IRQ-1:0]    w1s_bits;
  logic [IRQ_DATA_W-1:0] rd_mux;
  logic                  wr;
  logic                  vec_valid;
  logic [3:0]            vec_idx;
  logic                  unused_wdata;

  function automatic logic [IRQ_DATA_W-1:0] widen(logic [NUM_IRQ-1:0] v);
    logic [IRQ_DATA_W-1:0] r;
    r              = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    if (SYNC_STAGES == 0) begin : g_direct
      assign sync[i] = irq_in[i];
    end else begin : g_flops
      logic [SYNC_STAGES-1:0] sh_q;
      logic [SYNC_STAGES:0]   chain;
      assign chain = {sh_q, irq_in[i]};
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sh_q <= '0;
        else          sh_q <= chain[SYNC_STAGES-1:0];
      end
      assign sync[i] = chain[SYNC_STAGES];
    end
  end

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^bus.writedata;

  assign w1c_bits = (wr && bus.address == IRQ_ADDR_PENDING) ? wdata : '0;
  assign w1s_bits = (wr && bus.address == IRQ_ADDR_SET)     ? wdata : '0;

  // Capture is gated by the current mode, so set beats a same-cycle clear, and
  // switching a line to level discards anything it had latched.
  always_comb begin
    latch_d = ((latch_q & ~w1c_bits) | (sync & ~prev_q) | w1s_bits) & mode_q;
    if (wr && bus.address == IRQ_ADDR_MODE) latch_d = latch_d & wdata;
  end

  assign pending = (mode_q & latch_q) | (~mode_q & sync);
  assign active  = pending & mask_q;

  qsys_irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .req   (active),
    .valid (vec_valid),
    .idx   (vec_idx)
  );

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      IRQ_ADDR_PENDING: rd_mux = widen(pending);
      IRQ_ADDR_MASK:    rd_mux = widen(mask_q);
      IRQ_ADDR_MODE:    rd_mux = widen(mode_q);
      IRQ_ADDR_ACTIVE:  rd_mux = widen(active);
      IRQ_ADDR_VECTOR: begin
        rd_mux[VECTOR_VALID_BIT] = vec_valid;
        rd_mux[3:0]              = vec_idx;
      end
      IRQ_ADDR_RAW:     rd_mux = widen(sync);
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= '0;
      mask_q       <= '0;
      mode_q       <= '0;
      latch_q      <= '0;
      irq_out      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      prev_q       <= sync;
      latch_q      <= latch_d;
      irq_out      <= |active;
      bus.readdata <= rd_mux;
      if (wr && bus.address == IRQ_ADDR_MASK) mask_q <= wdata;
      if (wr && bus.address == IRQ_ADDR_MODE) mode_q <= wdata;
    end
  end

endmodule

// File: tb/tb_qsys_irq_ctrl.sv
// Bench for qsys_irq_ctrl: a 16-line direct-input instance checked every cycle against a
// rule-level model, plus a 4-line, 2-stage-synchroniser instance checked by hand.
module tb_qsys_irq_ctrl;
  import qsys_irq_pkg::*;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] irq_a   = '0;
  logic [3:0]  irq_b   = '0;
  logic        irq_out_a;
  logic        irq_out_b;

  qsys_irq_if bus_a ();
  qsys_irq_if bus_b ();

  qsys_irq_ctrl #(.NUM_IRQ(16), .SYNC_STAGES(0)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a),
    .irq_in  (irq_a),
    .irq_out (irq_out_a)
  );

  qsys_irq_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(2)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b),
    .irq_in  (irq_b),
    .irq_out (irq_out_b)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model of instance A: registers as plain words, per-line rules applied bit by bit.
  logic [15:0] m_mask = '0, m_mode = '0, m_edge = '0, m_prev = '0;
  logic [15:0] exp_rd = '0;
  logic        exp_irq = 1'b0;

  task automatic model_step();
    logic [15:0] pend, act, vec, wd;
    logic        w;
    logic [2:0]  ad;
    if (!reset_n) begin
      m_mask = '0; m_mode = '0; m_edge = '0; m_prev = '0;
      exp_rd = '0; exp_irq = 1'b0;
      return;
    end
    for (int i = 0; i < 16; i++) pend[i] = m_mode[i] ? m_edge[i] : irq_a[i];
    act = pend & m_mask;
    vec = '0;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) begin
        vec      = 16'h8000;
        vec[3:0] = 4'(i);
      end
    end
    ad = bus_a.address;
    case (ad)
      3'd0:    exp_rd = pend;
      3'd1:    exp_rd = m_mask;
      3'd2:    exp_rd = m_mode;
      3'd3:    exp_rd = act;
      3'd4:    exp_rd = vec;
      3'd6:    exp_rd = irq_a;
      default: exp_rd = '0;
    endcase
    exp_irq = (act != 0);
    w  = bus_a.chipselect && !bus_a.write_n;
    wd = bus_a.writedata;
    for (int i = 0; i < 16; i++) begin
      if (m_mode[i]) begin
        if ((irq_a[i] && !m_prev[i]) || (w && ad == 3'd5 && wd[i])) m_edge[i] = 1'b1;
        else if (w && ad == 3'd0 && wd[i])                           m_edge[i] = 1'b0;
      end
      if (w && ad == 3'd2 && !wd[i]) m_edge[i] = 1'b0;
      m_prev[i] = irq_a[i];
    end
    if (w && ad == 3'd1) m_mask = wd;
    if (w && ad == 3'd2) m_mode = wd;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_irq_out", 16'(irq_out_a), 16'(exp_irq));
      check("model_readdata", bus_a.readdata, exp_rd);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_a(input logic [2:0] addr, input logic [15:0] data);
    bus_a.address = addr; bus_a.writedata = data;
    bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    @(negedge clk);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
  endtask

  task automatic rd_a(input logic [2:0] addr, input logic [15:0] exp, input string name);
    bus_a.address = addr; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
    @(negedge clk);
    bus_a.chipselect = 1'b0;
    check(name, bus_a.readdata, exp);
  endtask

  task automatic wr_b(input logic [2:0] addr, input logic [15:0] data);
    bus_b.address = addr; bus_b.writedata = data;
    bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    @(negedge clk);
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic rd_b(input logic [2:0] addr, input logic [15:0] exp, input string name);
    bus_b.address = addr; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
    @(negedge clk);
    bus_b.chipselect = 1'b0;
    check(name, bus_b.readdata, exp);
  endtask

  initial begin
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset state, unused address, masked-off lines
    for (int a = 0; a < 8; a++) rd_a(3'(a), 16'h0000, $sformatf("reset_rd_addr%0d", a));
    irq_a = 16'hFFFF;
    tick(); tick();
    check("masked_irq_out", 16'(irq_out_a), 16'h0000);
    rd_a(IRQ_ADDR_RAW, 16'hFFFF, "raw_all_high");
    rd_a(IRQ_ADDR_PENDING, 16'hFFFF, "level_pending_all");
    irq_a = '0;
    tick();

    // Level line 0
    wr_a(IRQ_ADDR_MASK, 16'h0001);
    irq_a = 16'h0001;
    tick();
    check("level_irq_t1", 16'(irq_out_a), 16'h0001);
    wr_a(IRQ_ADDR_PENDING, 16'h0001);
    check("level_w1c_noeffect_irq", 16'(irq_out_a), 16'h0001);
    rd_a(IRQ_ADDR_PENDING, 16'h0001, "level_w1c_pending");
    irq_a = '0;
    tick();
    check("level_drop_irq", 16'(irq_out_a), 16'h0000);

    // Edge line 2
    wr_a(IRQ_ADDR_MODE, 16'h0004);
    wr_a(IRQ_ADDR_MASK, 16'h0004);
    irq_a = 16'h0004;
    tick();
    check("edge_irq_t1", 16'(irq_out_a), 16'h0000);
    irq_a = '0;
    tick();
    check("edge_irq_t2", 16'(irq_out_a), 16'h0001);
    rd_a(IRQ_ADDR_PENDING, 16'h0004, "edge_pending");
    wr_a(IRQ_ADDR_PENDING, 16'h0004);
    tick();
    check("edge_w1c_irq", 16'(irq_out_a), 16'h0000);
    irq_a = 16'h0004;
    tick();
    irq_a = '0;
    tick();
    irq_a = 16'h0004;
    wr_a(IRQ_ADDR_PENDING, 16'h0004);
    irq_a = '0;
    tick();
    check("edge_set_wins_irq", 16'(irq_out_a), 16'h0001);
    rd_a(IRQ_ADDR_PENDING, 16'h0004, "edge_set_wins_pending");

    // Priority vector
    wr_a(IRQ_ADDR_MODE, 16'h0000);
    wr_a(IRQ_ADDR_MASK, 16'hFFFF);
    irq_a = 16'h1088;
    rd_a(IRQ_ADDR_ACTIVE, 16'h1088, "active_3_7_12");
    rd_a(IRQ_ADDR_VECTOR, 16'h8003, "vector_3");
    irq_a = 16'h1080;
    rd_a(IRQ_ADDR_VECTOR, 16'h8007, "vector_7");
    irq_a = '0;
    rd_a(IRQ_ADDR_VECTOR, 16'h0000, "vector_none");

    // Software set, read-during-write, edge->level clear
    wr_a(IRQ_ADDR_MODE, 16'h0100);
    wr_a(IRQ_ADDR_SET, 16'h0101);
    rd_a(IRQ_ADDR_PENDING, 16'h0100, "sw_set_pending");
    rd_a(IRQ_ADDR_SET, 16'h0000, "set_reads_zero");
    check("sw_set_irq", 16'(irq_out_a), 16'h0001);
    wr_a(IRQ_ADDR_MASK, 16'h5555);
    check("read_during_write_old", bus_a.readdata, 16'hFFFF);
    wr_a(IRQ_ADDR_MODE, 16'h0000);
    rd_a(IRQ_ADDR_PENDING, 16'h0000, "mode_level_clears");

    // Narrow instance with two synchroniser stages
    wr_b(IRQ_ADDR_MASK, 16'hFFFF);
    rd_b(IRQ_ADDR_MASK, 16'h000F, "narrow_mask_read");
    irq_b = 4'h1;
    tick();
    check("sync_irq_t1", 16'(irq_out_b), 16'h0000);
    tick();
    check("sync_irq_t2", 16'(irq_out_b), 16'h0000);
    tick();
    check("sync_irq_t3", 16'(irq_out_b), 16'h0001);
    rd_b(IRQ_ADDR_RAW, 16'h0001, "sync_raw");
    irq_a = 16'h0001;
    tick();
    check("pre_reset_irq_a", 16'(irq_out_a), 16'h0001);

    // Asynchronous reset mid-pulse
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_irq_b", 16'(irq_out_b), 16'h0000);
    check("async_reset_irq_a", 16'(irq_out_a), 16'h0000);
    check("async_reset_rd_b", bus_b.readdata, 16'h0000);
    tick();
    reset_n = 1'b1;
    rd_b(IRQ_ADDR_MASK, 16'h0000, "post_reset_mask_b");
    tick(); tick();
    check("post_reset_masked_irq_b", 16'(irq_out_b), 16'h0000);
    rd_b(IRQ_ADDR_RAW, 16'h0001, "post_reset_raw_b");
    irq_a = '0;
    irq_b = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
